// File: rtl/prbs_word_gen.sv
// Pseudo-random word source: Fibonacci LFSR packed into OUT_W-bit words,
// optional rejection sampling to 0..RANGE-1, and a FWFT output FIFO.
module prbs_word_gen #(
  parameter int unsigned         LFSR_W = 15,
  parameter logic [LFSR_W-1:0]   TAPS   = 15'h0003,
  parameter logic [LFSR_W-1:0]   SEED   = 15'h4A80,
  parameter int unsigned         OUT_W  = 6,
  parameter int unsigned         RANGE  = 7,
  parameter int unsigned         DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam longint unsigned MAX_RANGE = 64'd1 << OUT_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (SEED == '0) begin : g_bad_seed
    $error("prbs_word_gen: SEED must be nonzero");
  end
  if (RANGE == 0 || 64'(RANGE) > MAX_RANGE) begin : g_bad_range
    $error("prbs_word_gen: RANGE must be 1..2^OUT_W");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("prbs_word_gen: DEPTH must be a power of two in 2..16");
  end
  if (LFSR_W < 4 || LFSR_W > 32) begin : g_bad_lfsr_w
    $error("prbs_word_gen: LFSR_W must be 4..32");
  end
  if (OUT_W < 1 || OUT_W > 16) begin : g_bad_out_w
    $error("prbs_word_gen: OUT_W must be 1..16");
  end

  // generator
  logic [LFSR_W-1:0] state;
  logic [CW-1:0]     cnt;
  logic [OUT_W-1:0]  acc;
  logic              fb;
  logic [OUT_W-1:0]  word_next;
  logic              step;
  logic              word_done;

  assign fb   = ^(state & TAPS);
  assign step = !seed_load && (state != '0);
  assign word_done = step && (cnt == CNT_LAST);

  if (OUT_W == 1) begin : g_w1
    assign word_next = fb;
  end else begin : g_wn
    assign word_next = {fb, acc[OUT_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
      cnt   <= '0;
      acc   <= '0;
    end else if (seed_load) begin
      state <= (seed_in == '0) ? SEED : seed_in;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == '0) begin
      state <= SEED;
    end else begin
      state <= {fb, state[LFSR_W-1:1]};
      acc   <= word_next;
      cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // candidate stage; mode is captured with the word it applies to
  logic [OUT_W-1:0] cand;
  logic             cand_stb;
  logic             cand_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand      <= '0;
      cand_stb  <= 1'b0;
      cand_mode <= 1'b0;
    end else begin
      cand_stb <= word_done;
      if (word_done) begin
        cand      <= word_next;
        cand_mode <= mode;
      end
    end
  end

  // filter stage
  logic             in_range;
  logic             accept;
  logic             push;
  logic [OUT_W-1:0] push_data;

  assign in_range = 32'(cand) < RANGE;
  assign accept   = cand_stb && (!cand_mode || in_range);

  always_ff @(posedge clk) begin
    if (rst) begin
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push <= accept;
      if (accept) begin
        push_data <= cand;
      end
    end
  end

  // output fifo
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [OUT_W-1:0] hold;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             drop;

  assign full    = (count == FULL_CNT);
  assign pop     = dout_valid && dout_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign dout_valid = (count != '0);
  assign dout       = dout_valid ? mem[rd_ptr] : hold;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold   <= mem[rd_ptr];
      end
      unique case ({do_push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
